// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer.
// Contents: register word offsets, CTRL bit positions, MODE codes and the
// FSM state encoding used by timer_counter.
package timer_pkg;

    // Word offsets within the block (byte address bits [3:2])
    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PRESET   = 2'd1;
    localparam logic [1:0] ADDR_COUNT    = 2'd2;
    localparam logic [1:0] ADDR_PRESCALE = 2'd3;

    // CTRL layout; bits above CTRL_W-1 read as zero
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    // MODE codes; 10/11 behave like one-shot but keep their written value
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 8-bit divider producing a decrement enable for the timer.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart the divider from 0 (counter load or decrement)
//   prescale   : terminal value; tick fires every prescale+1 cycles
//   tick       : high while the divider equals prescale
module timer_prescaler
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [7:0] prescale,
    output logic       tick
);

    logic [7:0] div_reg;

    assign tick = (div_reg == prescale);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + 8'd1;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer, interrupt source for CP0 HWInt[0].
// Software writes PRESET and CTRL; the FSM loads COUNT from PRESET, counts
// down to zero and raises irq once (one-shot) or periodically (auto-reload).
// Build option: define TIMER_PRESCALE_EN to add the PRESCALE register at
// offset 3 and a decrement divider; otherwise offset 3 reads 0.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   addr       : word offset 0=CTRL 1=PRESET 2=COUNT 3=PRESCALE/reserved
//   we, wdata  : bus write, takes effect at posedge
//   rdata      : combinational read of the register selected by addr
//   irq        : registered irq_pending & CTRL.IM
module timer_counter
    import timer_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [CTRL_W-1:0]  ctrl_reg;
    logic [CTRL_W-1:0]  ctrl_next;
    logic [COUNT_W-1:0] preset_reg;
    logic [COUNT_W-1:0] count_reg;
    state_t             state_reg;
    logic               pend_reg;
    logic               pend_next;
    logic               irq_reg;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        en;
    logic [1:0]  mode;
    logic        count_zero;
    logic        enter_int;
    logic        hw_clr_en;
    logic        dec;
    logic        tick;
    logic [31:0] prescale_rd;

    // Only part of wdata lands in registers for narrow configurations
    logic        unused_wdata;
    assign unused_wdata = ^wdata;

    assign wr_ctrl    = we && (addr == ADDR_CTRL);
    assign wr_preset  = we && (addr == ADDR_PRESET);
    assign en         = ctrl_reg[CTRL_EN];
    assign mode       = ctrl_reg[CTRL_MODE_HI:CTRL_MODE_LO];
    assign count_zero = (count_reg == '0);

    // COUNT==0 is checked every cycle; the divider only gates the decrement
    assign enter_int  = (state_reg == ST_CNT) && en && count_zero;
    assign dec        = (state_reg == ST_CNT) && en && !count_zero && tick;
    assign hw_clr_en  = (state_reg == ST_INT) && (mode != MODE_RELOAD);

    always_comb begin
        ctrl_next = ctrl_reg;
        if (hw_clr_en) begin
            ctrl_next[CTRL_EN] = 1'b0;
        end
        // A software write in the same cycle overrides the hardware EN clear
        if (wr_ctrl) begin
            ctrl_next = wdata[CTRL_W-1:0];
        end
    end

    always_comb begin
        pend_next = pend_reg;
        if ((state_reg == ST_INT) && (mode == MODE_RELOAD)) begin
            pend_next = 1'b0;
        end
        if (wr_ctrl || wr_preset) begin
            pend_next = 1'b0;
        end
        // Entering INT beats any clear in the same cycle
        if (enter_int) begin
            pend_next = 1'b1;
        end
    end

`ifdef TIMER_PRESCALE_EN
    logic [7:0] prescale_reg;
    logic       div_clear;

    assign div_clear   = (state_reg == ST_LOAD) || dec;
    assign prescale_rd = {24'd0, prescale_reg};

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_reg <= '0;
        end else if (we && (addr == ADDR_PRESCALE)) begin
            prescale_reg <= wdata[7:0];
        end
    end

    timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (div_clear),
        .prescale (prescale_reg),
        .tick     (tick)
    );
`else
    assign tick        = 1'b1;
    assign prescale_rd = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_reg   <= '0;
            preset_reg <= '0;
            count_reg  <= '0;
            state_reg  <= ST_IDLE;
            pend_reg   <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            ctrl_reg <= ctrl_next;
            pend_reg <= pend_next;
            // irq follows the new pending/mask values on the same edge
            irq_reg  <= pend_next & ctrl_next[CTRL_IM];
            if (wr_preset) begin
                preset_reg <= wdata[COUNT_W-1:0];
            end
            case (state_reg)
                ST_IDLE: begin
                    if (en) begin
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count_reg <= preset_reg;
                    state_reg <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en) begin
                        state_reg <= ST_IDLE;
                    end else if (count_zero) begin
                        state_reg <= ST_INT;
                    end else if (tick) begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                ST_INT: begin
                    if (mode == MODE_RELOAD) begin
                        state_reg <= ST_LOAD;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:     rdata = 32'(ctrl_reg);
            ADDR_PRESET:   rdata = 32'(preset_reg);
            ADDR_COUNT:    rdata = 32'(count_reg);
            ADDR_PRESCALE: rdata = prescale_rd;
            default:       rdata = '0;
        endcase
    end

    assign irq = irq_reg;

endmodule

// File: tb/tb_timer_counter.sv
// Testbench for timer_counter. Expected irq rising edges are computed from
// the latency rules (first irq N+3 edges after the enabling write, period
// N+3 in auto-reload, N*(PRESCALE+1)+3 with a prescaler) and queued; a
// monitor pops one entry per observed rising edge of irq.
module tb_timer_counter;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr  = 2'd0;
    logic        we    = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int sbq[$];
    int exp_e;
    logic irq_prev = 1'b0;

    timer_counter #(.COUNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; stable at negedge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int e);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        e  = cyc;
        $display("write  addr=%0d data=0x%08h landed at edge %0d", a, d, e);
    endtask

    task automatic chk_rd(input string name, input logic [1:0] a, input logic [31:0] req);
        addr = a;
        #1;
        $display("read   addr=%0d data=0x%08h at edge %0d", a, rdata, cyc);
        chk(name, rdata, req);
    endtask

    task automatic wait_to(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    // Scoreboard monitor: every rising edge of irq must match the next
    // scheduled edge number
    always @(negedge clk) begin
        if (!reset && irq && !irq_prev) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL irq_rise: unexpected rise at edge %0d, none scheduled", cyc);
            end else begin
                exp_e = sbq.pop_front();
                $display("irq    rise at edge %0d (scheduled %0d)", cyc, exp_e);
                if (cyc != exp_e) begin
                    failures++;
                    $display("FAIL irq_rise: rise at edge %0d, expected edge %0d", cyc, exp_e);
                end
            end
        end
        irq_prev = irq;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not finish, got edge %0d, expected completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int e0;
        int e1;

        // Reset while the bus hammers every register with all-ones
        we    = 1'b1;
        wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            addr = i[1:0];
            @(posedge clk);
            #1;
        end
        we    = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk_rd($sformatf("reset_reg%0d", i), i[1:0], 32'd0);
        chk("reset_irq", irq, 1'b0);
        repeat (3) @(negedge clk);
        chk_rd("idle_count", 2'd2, 32'd0);

        // One-shot with mask open: COUNT=5 at e0+2, 0 at e0+7, irq from e0+8
        wr(2'd1, 32'd5, t);
        wr(2'd0, 32'h9, e0);
        sbq.push_back(e0 + 8);
        wait_to(e0 + 2);  chk_rd("m0_count_load", 2'd2, 32'd5);
        wait_to(e0 + 7);  chk_rd("m0_count_zero", 2'd2, 32'd0);
        chk("m0_irq_before", irq, 1'b0);
        wait_to(e0 + 8);  chk("m0_irq_rise", irq, 1'b1);
        wait_to(e0 + 12); chk("m0_irq_held", irq, 1'b1);
        chk_rd("m0_ctrl_en_cleared", 2'd0, 32'h8);
        wr(2'd1, 32'd7, e1);
        chk("m0_irq_cleared_by_preset", irq, 1'b0);

        // Auto-reload PRESET=3: pulses every 6 edges, EN stays set
        wr(2'd1, 32'd3, t);
        wr(2'd0, 32'hB, e0);
        for (int k = 1; k <= 5; k++) sbq.push_back(e0 + 6 * k);
        wait_to(e0 + 7);  chk("m1_pulse_width", irq, 1'b0);
        wait_to(e0 + 31); chk_rd("m1_ctrl_en_kept", 2'd0, 32'hB);
        wr(2'd0, 32'h0, t);
        wait_to(e0 + 40); chk("m1_stopped", irq, 1'b0);
        chk("m1_sb_empty", sbq.size(), 32'd0);

        // Masked one-shot: pending set but irq stays low; a CTRL write that
        // opens the mask also clears pending, so irq must remain low
        wr(2'd1, 32'd2, t);
        wr(2'd0, 32'h1, e0);
        wait_to(e0 + 8);  chk("mask_irq_low", irq, 1'b0);
        chk_rd("mask_ctrl_en_cleared", 2'd0, 32'h0);
        wr(2'd0, 32'h8, e1);
        chk("mask_write_clears_pending", irq, 1'b0);
        wait_to(e1 + 3);  chk("mask_irq_stays_low", irq, 1'b0);

        // Disable mid-count: the edge that lands EN=0 still decrements
        // (FSM sees the old EN), so writing while COUNT=5 holds at 4
        wr(2'd1, 32'd10, t);
        wr(2'd0, 32'h1, e0);
        wait_to(e0 + 7);  chk_rd("dis_count_before", 2'd2, 32'd5);
        wr(2'd0, 32'h0, e1);
        wait_to(e1 + 4);  chk_rd("dis_count_held", 2'd2, 32'd4);
        wr(2'd0, 32'h1, e1);
        wait_to(e1 + 1);  chk_rd("reen_in_load", 2'd2, 32'd4);
        wait_to(e1 + 2);  chk_rd("reen_reloaded", 2'd2, 32'd10);
        wr(2'd0, 32'h0, t);

`ifdef TIMER_PRESCALE_EN
        // PRESCALE=2, PRESET=2: decrement every 3 cycles, irq at 2*3+3
        wr(2'd3, 32'd2, t);
        wr(2'd1, 32'd2, t);
        wr(2'd0, 32'h9, e0);
        sbq.push_back(e0 + 9);
        chk_rd("ps_readback", 2'd3, 32'd2);
        wait_to(e0 + 2); chk_rd("ps_count_load", 2'd2, 32'd2);
        wait_to(e0 + 4); chk_rd("ps_count_hold", 2'd2, 32'd2);
        wait_to(e0 + 5); chk_rd("ps_count_step1", 2'd2, 32'd1);
        wait_to(e0 + 8); chk_rd("ps_count_step2", 2'd2, 32'd0);
        chk("ps_irq_before", irq, 1'b0);
        wait_to(e0 + 9); chk("ps_irq_rise", irq, 1'b1);
        wr(2'd0, 32'h0, t);
        wr(2'd3, 32'h0, t);
`else
        wr(2'd3, 32'hFF, t);
        chk_rd("reserved_reads_zero", 2'd3, 32'd0);
`endif

        // Randomized transactions against the latency model
        for (int n = 0; n < 10; n++) begin
            int pv;
            int md;
            int per;
            int lat;
            pv  = $urandom_range(0, 12);
            md  = $urandom_range(0, 3);
            per = $urandom_range(2, 4);
            lat = pv + 3;
            wr(2'd1, pv, t);
            wr(2'd0, {28'd0, 1'b1, md[1:0], 1'b1}, e0);
            if (md == 1) begin
                for (int k = 1; k <= per; k++) sbq.push_back(e0 + lat * k);
            end else begin
                sbq.push_back(e0 + lat);
            end
            // COUNT is read-only: a write landing with the load is ignored
            wait_to(e0 + 1);
            wr(2'd2, $urandom, t);
            chk_rd("rnd_count_load", 2'd2, pv);
            if (md == 1) begin
                wait_to(e0 + lat * per + 1);
                chk_rd("rnd_reload_ctrl", 2'd0, {28'd0, 1'b1, md[1:0], 1'b1});
                wr(2'd0, 32'h0, t);
            end else begin
                wait_to(e0 + lat + 3);
                chk("rnd_oneshot_held", irq, 1'b1);
                chk_rd("rnd_oneshot_ctrl", 2'd0, {28'd0, 1'b1, md[1:0], 1'b0});
                wr(2'd0, 32'h0, t);
                chk("rnd_oneshot_cleared", irq, 1'b0);
            end
            wait_to(t + 4);
        end

        // Reset while irq is held: everything returns to zero on that edge
        wr(2'd1, 32'd1, t);
        wr(2'd0, 32'h9, e0);
        sbq.push_back(e0 + 4);
        wait_to(e0 + 6); chk("rst_pre_irq", irq, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_irq_drop", irq, 1'b0);
        chk_rd("rst_ctrl", 2'd0, 32'd0);
        chk_rd("rst_preset", 2'd1, 32'd0);
        chk_rd("rst_count", 2'd2, 32'd0);

        repeat (5) @(negedge clk);
        chk("sb_drained", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
